addw_share_arb: RTL

Round-robin arbiter and two-stage sequencer that time-shares one `addw` adder among `NREQ` requesters.

- Each requester presents an operand pair plus predicate through a valid/ready handshake.
- The block grants one requester per cycle, registers its operands into the adder stage, and captures the sum with the requester's ID.
- The result is returned on a single valid/ready result port.
- It sits between the scheduled datapath clients and the adder macrocell, replacing per-client adders.

---
 rtl/addw_share_arb.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/addw_share_arb.sv
// -----------------------------------------------------------------------------
// addw_share_arb
//
// Round-robin arbiter and two-stage sequencer that time-shares a single `addw`
// adder among NREQ requesters. Each requester offers an operand pair and a
// predicate through valid/ready. One requester is granted per cycle. Its
// operands are registered into the issue stage (S1), which drives the adder.
// The sum is then captured into the result stage (S2) together with the
// requester's index.
//
// Optional feature: define ADDW_SHARE_ARB_CARRY_EN to widen the adder by one
// bit and expose the carry-out on res_carry. With the macro undefined the
// res_carry port does not exist. Handshake and timing are the same in both
// builds.
//
// Parameters:
//   WIDTH       operand/result width (forwarded to addw as `width`)
//   NREQ        number of requesters, 2..8
// Ports:
//   clk         clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   req_valid   per-requester operation pending
//   req_ready   per-requester accept this cycle (one-hot or zero)
//   req_a/req_b packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_pred    per-requester predicate
//   res_valid   result register holds a result
//   res_ready   consumer takes the result this cycle
//   res_data    A+B mod 2^WIDTH
//   res_id      issuing requester index, zero-extended to 3 bits
//   res_enable  registered predicate of the operation
//   res_carry   carry-out (ADDW_SHARE_ARB_CARRY_EN builds only)
// -----------------------------------------------------------------------------

// Adder macrocell model: plain combinational add. The enable is passed through
// so that the predicate travels alongside the sum.
module addw #(
  parameter int width = 16
) (
  input  logic [width-1:0] i0_a,
  input  logic [width-1:0] i0_b,
  input  logic             i0_enable,
  output logic [width-1:0] o0_sum,
  output logic             o0_enable
);
  assign o0_sum    = i0_a + i0_b;
  assign o0_enable = i0_enable;
endmodule

module addw_share_arb #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_pred,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [2:0]            res_id,
  output logic                  res_enable
`ifdef ADDW_SHARE_ARB_CARRY_EN
  ,
  output logic                  res_carry
`endif
);

  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W1 = PTR_W + 1;
`ifdef ADDW_SHARE_ARB_CARRY_EN
  localparam int ADD_W  = WIDTH + 1;
`else
  localparam int ADD_W  = WIDTH;
`endif

  // Round-robin pointer
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // S1: issue register
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] b1_q, b1_d;
  logic             pred1_q, pred1_d;
  logic [PTR_W-1:0] id1_q, id1_d;

  // S2: result register
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] data2_q, data2_d;
  logic [PTR_W-1:0] id2_q, id2_d;
  logic             en2_q, en2_d;
`ifdef ADDW_SHARE_ARB_CARRY_EN
  logic             carry2_q, carry2_d;
`endif

  // Arbitration
  logic [NREQ-1:0]  grant;
  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W1-1:0] scan_sum;
  logic [PTR_W-1:0] scan_idx;

  // Handshake
  logic s1_load, s2_load, accept;

  // Adder connections
  logic [ADD_W-1:0] add_a, add_b, add_sum;
  logic             add_en;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  // NOTE: every signal assigned in an always_comb gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + PTR_W1'(k);
      if (scan_sum >= PTR_W1'(NREQ)) scan_sum = scan_sum - PTR_W1'(NREQ);
      scan_idx = scan_sum[PTR_W-1:0];
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any       = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  // S2 accepts from S1 when it is empty or is draining this cycle. S1 accepts
  // a new grant when it is empty or is handing its contents to S2. This gives
  // full throughput with no bubble when both stages are occupied.
  assign s2_load   = v1_q & (~v2_q | res_ready);
  assign s1_load   = ~v1_q | s2_load;
  assign accept    = grant_any & s1_load & ~reset;
  assign req_ready = grant & {NREQ{s1_load & ~reset}};

`ifdef ADDW_SHARE_ARB_CARRY_EN
  assign add_a = {1'b0, a1_q};
  assign add_b = {1'b0, b1_q};
`else
  assign add_a = a1_q;
  assign add_b = b1_q;
`endif

  addw #(
    .width(ADD_W)
  ) u_addw (
    .i0_a      (add_a),
    .i0_b      (add_b),
    .i0_enable (pred1_q),
    .o0_sum    (add_sum),
    .o0_enable (add_en)
  );

  always_comb begin
    ptr_d   = ptr_q;
    v1_d    = v1_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    pred1_d = pred1_q;
    id1_d   = id1_q;
    v2_d    = v2_q;
    data2_d = data2_q;
    id2_d   = id2_q;
    en2_d   = en2_q;
`ifdef ADDW_SHARE_ARB_CARRY_EN
    carry2_d = carry2_q;
`endif

    if (accept) begin
      ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // S1 empties when it hands off and nobody is granted.
    if (s1_load) begin
      v1_d = grant_any;
      if (grant_any) begin
        a1_d    = req_a[grant_idx*WIDTH +: WIDTH];
        b1_d    = req_b[grant_idx*WIDTH +: WIDTH];
        pred1_d = req_pred[grant_idx];
        id1_d   = grant_idx;
      end
    end

    if (s2_load) begin
      v2_d    = 1'b1;
      data2_d = add_sum[WIDTH-1:0];
      id2_d   = id1_q;
      en2_d   = add_en;
`ifdef ADDW_SHARE_ARB_CARRY_EN
      carry2_d = add_sum[WIDTH];
`endif
    end else if (res_ready && v2_q) begin
      v2_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  // Datapath registers are reset too because the result outputs have defined
  // reset values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      v1_q     <= 1'b0;
      a1_q     <= '0;
      b1_q     <= '0;
      pred1_q  <= 1'b0;
      id1_q    <= '0;
      v2_q     <= 1'b0;
      data2_q  <= '0;
      id2_q    <= '0;
      en2_q    <= 1'b0;
`ifdef ADDW_SHARE_ARB_CARRY_EN
      carry2_q <= 1'b0;
`endif
    end else begin
      ptr_q    <= ptr_d;
      v1_q     <= v1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      pred1_q  <= pred1_d;
      id1_q    <= id1_d;
      v2_q     <= v2_d;
      data2_q  <= data2_d;
      id2_q    <= id2_d;
      en2_q    <= en2_d;
`ifdef ADDW_SHARE_ARB_CARRY_EN
      carry2_q <= carry2_d;
`endif
    end
  end

  assign res_valid  = v2_q;
  assign res_data   = data2_q;
  assign res_id     = 3'(id2_q);
  assign res_enable = en2_q;
`ifdef ADDW_SHARE_ARB_CARRY_EN
  assign res_carry  = carry2_q;
`endif

endmodule
